// File: rtl/dcim_pkg.sv
// Shared types for the tinydcim sequencer: command opcodes, FSM states and the column-sum width helper.
package dcim_pkg;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_WRITE_ROW = 2'b01,
    OP_MAC       = 2'b10,
    OP_CLEAR     = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int cs_w(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/dcim_bitserial_acc.sv
// Per-column shift-add accumulator bank; one update per enabled cycle, clr has priority, no backpressure.
// DCIM_SIGNED_ACT_EN: the first (MSB) slice is negated so results are two's complement.
module dcim_bitserial_acc
  import dcim_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ACC_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic                        i_first,
  input  logic [COLS*cs_w(ROWS)-1:0]  i_colsum,
  output logic [COLS*ACC_W-1:0]       o_acc
);

  localparam int CS_W = cs_w(ROWS);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_cs;

    assign w_cs = {{(ACC_W-CS_W){1'b0}}, i_colsum[c*CS_W +: CS_W]};

    // The first slice loads directly, so a stale accumulator can never leak into a new result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
`ifdef DCIM_SIGNED_ACT_EN
        if (i_first) r_acc <= '0 - w_cs;
`else
        if (i_first) r_acc <= w_cs;
`endif
        else         r_acc <= (r_acc << 1) + w_cs;
      end
    end

    assign o_acc[c*ACC_W +: ACC_W] = r_acc;
  end

endmodule

// File: rtl/dcim_seq_ctrl.sv
// DCIM command sequencer: WRITE 1 cycle, CLEAR ROWS cycles, MAC result valid ACT_BITS+2 edges after accept.
// Commands accepted only in IDLE; DONE holds res_data until res_ready. Optional macro: DCIM_SIGNED_ACT_EN.
module dcim_seq_ctrl
  import dcim_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int ACT_BITS = 4,
  parameter int ACC_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(ROWS)-1:0]     cmd_addr,
  input  logic [COLS-1:0]             cmd_data,
  input  logic [ROWS*ACT_BITS-1:0]    cmd_act,
  output logic                        arr_we,
  output logic [$clog2(ROWS)-1:0]     arr_waddr,
  output logic [COLS-1:0]             arr_wdata,
  output logic                        arr_act_en,
  output logic [ROWS-1:0]             arr_act_bits,
  input  logic [COLS*cs_w(ROWS)-1:0]  arr_colsum,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [COLS*ACC_W-1:0]       res_data,
  output logic                        busy
);

  localparam int AW    = $clog2(ROWS);
  localparam int CS_W  = cs_w(ROWS);
  localparam int CNT_W = $clog2(ROWS + ACT_BITS + 2);
  localparam int BIT_W = $clog2(ACT_BITS);

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [AW-1:0]           r_addr;
  logic [COLS-1:0]         r_data;
  logic [ROWS*ACT_BITS-1:0] r_act;
  logic                    r_act_d, r_first_d, r_cs_vld, r_cs_first;
  logic [COLS*CS_W-1:0]    r_colsum;
  logic                    w_accept, w_mac_go;
  logic [BIT_W-1:0]        w_bit;
  logic [ROWS-1:0]         w_slice;
  cmd_op_e                 w_op;

  assign w_op     = cmd_op_e'(cmd_op);
  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_mac_go = w_accept && (w_op == OP_MAC);
  assign w_bit    = BIT_W'(ACT_BITS - 1) - r_cnt[BIT_W-1:0];

  for (genvar r = 0; r < ROWS; r++) begin : g_slice
    logic [ACT_BITS-1:0] w_row;
    assign w_row      = r_act[r*ACT_BITS +: ACT_BITS];
    assign w_slice[r] = w_row[w_bit];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_cnt <= '0;
    else if (w_state_nxt != r_state)   r_cnt <= '0;
    else if (r_state == ST_CLEAR || r_state == ST_COMPUTE || r_state == ST_DRAIN)
                                       r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_act  <= '0;
    end else if (w_accept) begin
      r_addr <= cmd_addr;
      r_data <= cmd_data;
      r_act  <= cmd_act;
    end
  end

  // Column sums are flopped before the adders; DRAIN covers both the array and this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_d    <= 1'b0;
      r_first_d  <= 1'b0;
      r_cs_vld   <= 1'b0;
      r_cs_first <= 1'b0;
      r_colsum   <= '0;
    end else begin
      r_act_d    <= arr_act_en;
      r_first_d  <= arr_act_en && (r_cnt == '0);
      r_cs_vld   <= r_act_d;
      r_cs_first <= r_first_d;
      r_colsum   <= arr_colsum;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    arr_we       = 1'b0;
    arr_waddr    = '0;
    arr_wdata    = '0;
    arr_act_en   = 1'b0;
    arr_act_bits = '0;
    res_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (w_op)
            OP_WRITE_ROW: w_state_nxt = ST_WRITE;
            OP_MAC:       w_state_nxt = ST_COMPUTE;
            OP_CLEAR:     w_state_nxt = ST_CLEAR;
            default:      w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: begin
        arr_we      = 1'b1;
        arr_waddr   = r_addr;
        arr_wdata   = r_data;
        w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = r_cnt[AW-1:0];
        if (r_cnt == CNT_W'(ROWS - 1)) w_state_nxt = ST_IDLE;
      end
      ST_COMPUTE: begin
        arr_act_en   = 1'b1;
        arr_act_bits = w_slice;
        if (r_cnt == CNT_W'(ACT_BITS - 1)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  dcim_bitserial_acc #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_mac_go),
    .i_en     (r_cs_vld),
    .i_first  (r_cs_first),
    .i_colsum (r_colsum),
    .o_acc    (res_data)
  );

endmodule

// File: tb/tb_dcim_seq_ctrl.sv
// Bench for dcim_seq_ctrl: array model drives colsum, a transaction-level model predicts every output each cycle.
module tb_dcim_seq_ctrl;
  import dcim_pkg::*;

  localparam int ROWS = 8, COLS = 8, ACT_BITS = 4, ACC_W = 8, CS_W = 4, AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     cmd_valid = 1'b0, cmd_ready;
  logic [1:0]               cmd_op = 2'b00;
  logic [AW-1:0]            cmd_addr = '0;
  logic [COLS-1:0]          cmd_data = '0;
  logic [ROWS*ACT_BITS-1:0] cmd_act = '0;
  logic                     arr_we, arr_act_en, res_valid, busy;
  logic [AW-1:0]            arr_waddr;
  logic [COLS-1:0]          arr_wdata;
  logic [ROWS-1:0]          arr_act_bits;
  logic [COLS*CS_W-1:0]     arr_colsum = '0;
  logic                     res_ready = 1'b0;
  logic [COLS*ACC_W-1:0]    res_data;

  dcim_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .ACT_BITS(ACT_BITS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_act(cmd_act), .arr_we(arr_we),
    .arr_waddr(arr_waddr), .arr_wdata(arr_wdata), .arr_act_en(arr_act_en),
    .arr_act_bits(arr_act_bits), .arr_colsum(arr_colsum), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // DCIM array macro: weight storage plus registered per-column popcount; garbage when not computing.
  logic [COLS-1:0] amem [ROWS] = '{default: '0};

  function automatic logic [COLS*CS_W-1:0] popcols(input logic [ROWS-1:0] bits);
    logic [COLS*CS_W-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < ROWS; r++) if (bits[r] && amem[r][c]) s++;
      v[c*CS_W +: CS_W] = CS_W'(s);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (arr_we) amem[arr_waddr] <= arr_wdata;
    arr_colsum <= arr_act_en ? popcols(arr_act_bits) : $urandom;
  end

  // Transaction-level reference: mode 0 idle, 1 write, 2 clear, 3 mac busy, 4 result held.
  logic [COLS-1:0]          wm [ROWS] = '{default: '0};
  int                       m_mode = 0, m_j = 0;
  logic [AW-1:0]            m_addr = '0;
  logic [COLS-1:0]          m_data = '0;
  logic [ROWS*ACT_BITS-1:0] m_act = '0;
  logic [63:0]              m_res = '0;

  function automatic logic [63:0] mac_ref(input logic [ROWS*ACT_BITS-1:0] act);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      int sum;
      sum = 0;
      for (int r = 0; r < ROWS; r++) begin
        int a;
        a = int'(act[r*ACT_BITS +: ACT_BITS]);
`ifdef DCIM_SIGNED_ACT_EN
        if (a >= (1 << (ACT_BITS - 1))) a -= (1 << ACT_BITS);
`endif
        if (wm[r][c]) sum += a;
      end
      v[c*ACC_W +: ACC_W] = sum[ACC_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [ROWS-1:0] exp_slice(input logic [ROWS*ACT_BITS-1:0] act, input int k);
    logic [ROWS-1:0] b;
    for (int r = 0; r < ROWS; r++)
      b[r] = ((int'(act[r*ACT_BITS +: ACT_BITS]) >> (ACT_BITS - 1 - k)) & 1) != 0;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_j    = 0;
    end else begin
      case (m_mode)
        0: if (cmd_valid) begin
             m_j = 0; m_addr = cmd_addr; m_data = cmd_data; m_act = cmd_act;
             case (cmd_op)
               2'b01: begin m_mode = 1; wm[cmd_addr] = cmd_data; end
               2'b10: begin m_mode = 3; m_res = mac_ref(cmd_act); end
               2'b11: begin m_mode = 2; for (int r = 0; r < ROWS; r++) wm[r] = '0; end
               default: m_mode = 0;
             endcase
           end
        1: m_mode = 0;
        2: if (m_j == ROWS - 1) m_mode = 0; else m_j++;
        3: if (m_j == ACT_BITS + 1) m_mode = 4; else m_j++;
        4: if (res_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  int we_cnt = 0;
  int we_log [$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmd_ready", 64'(cmd_ready), 64'(m_mode == 0));
      check("busy", 64'(busy), 64'(m_mode != 0));
      check("res_valid", 64'(res_valid), 64'(m_mode == 4));
      if (m_mode == 4) check("res_data", res_data, m_res);
      check("arr_we", 64'(arr_we), 64'(m_mode == 1 || m_mode == 2));
      if (m_mode == 1 || m_mode == 2) begin
        check("arr_waddr", 64'(arr_waddr), (m_mode == 1) ? 64'(m_addr) : 64'(m_j));
        check("arr_wdata", 64'(arr_wdata), (m_mode == 1) ? 64'(m_data) : 64'd0);
      end
      check("arr_act_en", 64'(arr_act_en), 64'(m_mode == 3 && m_j < ACT_BITS));
      if (m_mode == 3 && m_j < ACT_BITS)
        check("arr_act_bits", 64'(arr_act_bits), 64'(exp_slice(m_act, m_j)));
      if (arr_we) begin
        we_cnt++;
        we_log.push_back(int'(arr_waddr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [COLS-1:0] d,
                      input logic [ROWS*ACT_BITS-1:0] act, input bit keep, output int waited);
    logic rdy;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_act = act;
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = cmd_ready;
      tick();
      waited++;
      if (rdy) begin
        if (!keep) cmd_valid = 1'b0;
        return;
      end
    end
    n_chk++; n_err++;
    $display("FAIL send_timeout: got no acceptance expected cmd_ready");
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      edges++;
      if (res_valid) return;
    end
    n_chk++; n_err++;
    $display("FAIL done_timeout: got res_valid=0 expected 1");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) return;
      tick();
    end
    n_chk++; n_err++;
    $display("FAIL idle_timeout: got cmd_ready=0 expected 1");
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

`ifdef DCIM_SIGNED_ACT_EN
  localparam logic [63:0] EXP_ALL = {8{8'hF8}};
`else
  localparam logic [63:0] EXP_ALL = {8{8'd120}};
`endif

  initial begin
    int w, e;
    logic [63:0] exp_bp;
    logic [1:0] op;
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_arr_we", 64'(arr_we), 64'd0);
    check("rst_act_en", 64'(arr_act_en), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < ROWS; r++) send(2'b01, AW'(r), 8'hFF, '0, 1'b0, w);
    send(2'b10, '0, '0, {(ROWS*ACT_BITS){1'b1}}, 1'b0, w);
    wait_done(e);
    check("mac_latency", 64'(e), 64'd6);
    check("mac_all_ones", res_data, EXP_ALL);
    release_res();

    we_cnt = 0;
    we_log.delete();
    send(2'b11, '0, '0, '0, 1'b0, w);
    wait_idle();
    check("clear_we_cycles", 64'(we_cnt), 64'd8);
    for (int i = 0; i < ROWS; i++)
      if (i < we_log.size()) check("clear_addr_order", 64'(we_log[i]), 64'(i));
    send(2'b01, 3'd0, 8'h01, '0, 1'b0, w);
    send(2'b10, '0, '0, 32'h0000_0005, 1'b0, w);
    wait_done(e);
    check("mac_row0_act5", res_data, 64'h5);
    release_res();

    exp_bp = mac_ref(32'h0000_00F3);
    send(2'b10, '0, '0, 32'h0000_00F3, 1'b0, w);
    wait_done(e);
    repeat (10) tick();
    cmd_valid = 1'b1; cmd_op = 2'b11;
    tick();
    cmd_valid = 1'b0;
    check("bp_res_valid", 64'(res_valid), 64'd1);
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bp_res_data", res_data, exp_bp);
    release_res();
    check("bp_idle_after_ready", 64'(cmd_ready), 64'd1);

    send(2'b00, '0, '0, {(ROWS*ACT_BITS){1'b1}}, 1'b1, w);
    check("nop_accept_cycles", 64'(w), 64'd1);
    check("nop_no_act", 64'(arr_act_en), 64'd0);
    send(2'b01, 3'd3, 8'hA5, '0, 1'b1, w);
    check("write_accept_cycles", 64'(w), 64'd1);
    send(2'b10, '0, '0, 32'h1234_5678, 1'b0, w);
    check("mac_accept_cycles", 64'(w), 64'd2);
    wait_done(e);
    release_res();

    send(2'b10, '0, '0, {(ROWS*ACT_BITS){1'b1}}, 1'b0, w);
    tick();
    tick();
    check("pre_rst_act_en", 64'(arr_act_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_act_en", 64'(arr_act_en), 64'd0);
    check("rst_mid_we", 64'(arr_we), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_res_valid", 64'(res_valid), 64'd0);
    check("post_rst_res_data", res_data, 64'd0);
    tick();

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 100 && !cmd_ready; i++) begin
        res_ready = 1'($urandom % 2);
        tick();
      end
      res_ready = 1'b0;
      op = 2'($urandom % 4);
      send(op, AW'($urandom % ROWS), COLS'($urandom), $urandom, 1'b0, w);
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      res_ready = 1'b1;
      tick();
    end
    res_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
